// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add ops plus an iterative shift-add
// multiplier, with an architectural flag register written on request.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             fi,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 2);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               fi_q, fi_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    logic [WIDTH:0]     ext;
    logic [WIDTH:0]     cin_ext;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic [2*WIDTH-1:0] mul_sum;
    logic               accept;

    assign in_ready  = !rst && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;

    // Single-cycle datapath; carry flop is already current for ADC/SBC
    // because every single-cycle op writes flags on its acceptance edge.
    always_comb begin
        cin_ext = {{WIDTH{1'b0}}, carry_q};
        ext     = '0;
        res     = a;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b};
                if (op == OP_ADC) ext = ext + cin_ext;
                res   = ext[M:0];
                res_c = ext[WIDTH];
                res_v = (a[M] == b[M]) && (res[M] != a[M]);
            end
            OP_SUB, OP_SBC: begin
                ext = {1'b0, a} - {1'b0, b};
                if (op == OP_SBC) ext = ext - cin_ext;
                res   = ext[M:0];
                res_c = ext[WIDTH];
                res_v = (a[M] != b[M]) && (res[M] != a[M]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res   = {a[M-1:0], 1'b0};
                res_c = a[M];
            end
            OP_SHR: begin
                res   = {1'b0, a[M:1]};
                res_c = a[0];
            end
            default: res = a;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        fi_d        = fi_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mul_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (accept && op == OP_MUL) begin
                    // First partial product is taken on the accept edge.
                    state_d  = MUL_BUSY;
                    fi_d     = fi;
                    cnt_d    = CNT_INIT;
                    acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
                    mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
                    mplier_d = {1'b0, b[M:1]};
                end else if (accept) begin
                    out_d       = res;
                    out_valid_d = 1'b1;
                    if (fi) begin
                        carry_d = res_c;
                        zero_d  = (res == '0);
                        neg_d   = res[M];
                        ovf_d   = res_v;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = mul_sum;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[M:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    out_d       = mul_sum[M:0];
                    out_valid_d = 1'b1;
                    if (fi_q) begin
                        carry_d = |mul_sum[2*WIDTH-1:WIDTH];
                        zero_d  = (mul_sum[M:0] == '0);
                        neg_d   = mul_sum[M];
                        ovf_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            fi_q        <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            fi_q        <= fi_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8 with hand-computed results.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       fi;
    logic [7:0] out;
    logic       out_valid;
    logic       carry, zero, negative, overflow;

    int errs   = 0;
    int checks = 0;

    alu_mc #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .fi        (fi),
        .out       (out),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {carry, zero, negative, overflow};
    endfunction

    // Present one request for one edge; returns just after that edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic f);
        @(negedge clk);
        op = o; a = x; b = y; fi = f; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic alu1(input string tag, input logic [3:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic f, input logic [7:0] eo,
                        input logic [3:0] ef);
        issue(o, x, y, f);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flags"}, flags(), ef);
    endtask

    task automatic mul(input string tag, input logic [7:0] x,
                       input logic [7:0] y, input logic f,
                       input logic [7:0] eo, input logic [3:0] ef);
        int lat;
        logic rdy_hi;
        lat = 0;
        rdy_hi = 1'b0;
        issue(4'd10, x, y, f);
        while (lat < 20) begin
            lat++;
            if (out_valid) break;
            if (in_ready) rdy_hi = 1'b1;
            @(posedge clk);
            #1;
        end
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busy_rdy"}, rdy_hi, 1'b0);
        chk({tag, "_rdy_back"}, in_ready, 1'b1);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flags"}, flags(), ef);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; fi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_rdy", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", in_ready, 1'b1);

        // flags are {carry, zero, negative, overflow}
        alu1("add_ff_01", 4'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1100);
        alu1("adc_fwd", 4'd2, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000);
        alu1("add_ff_01b", 4'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1100);
        alu1("and_nofi", 4'd4, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b1100);
        alu1("sub_5_7", 4'd1, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b1010);
        alu1("sbc_10_1", 4'd3, 8'h10, 8'h01, 1'b1, 8'h0E, 4'b0000);
        alu1("sub_80_1", 4'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0001);
        alu1("add_ovf", 4'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011);
        alu1("or", 4'd5, 8'hA0, 8'h05, 1'b1, 8'hA5, 4'b0010);
        alu1("xor", 4'd6, 8'h5A, 8'h5A, 1'b1, 8'h00, 4'b0100);
        alu1("not", 4'd7, 8'h0F, 8'h00, 1'b1, 8'hF0, 4'b0010);
        alu1("shl", 4'd8, 8'h81, 8'h00, 1'b1, 8'h02, 4'b1000);
        alu1("shr", 4'd9, 8'h01, 8'h00, 1'b1, 8'h00, 4'b1100);
        alu1("pass15", 4'd15, 8'h80, 8'h33, 1'b1, 8'h80, 4'b0010);

        @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1'b0);
        chk("hold_out", out, 8'h80);

        mul("mul_0f_11", 8'h0F, 8'h11, 1'b1, 8'hFF, 4'b0010);
        mul("mul_10_10", 8'h10, 8'h10, 1'b1, 8'h00, 4'b1100);
        mul("mul_nofi", 8'h0D, 8'h0B, 1'b0, 8'h8F, 4'b1100);

        // Abort a multiply with reset; the request shown with rst is dropped.
        alu1("pre_abort", 4'd0, 8'h55, 8'h00, 1'b0, 8'h55, 4'b1100);
        issue(4'd10, 8'h0F, 8'h11, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        op = 4'd0; a = 8'hFF; b = 8'h01; fi = 1'b1; in_valid = 1'b1;
        #1;
        chk("rdy_in_rst", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_out", out, 8'h00);
        chk("abort_flags", flags(), 4'b0000);
        chk("abort_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_rdy", in_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_out_hold", out, 8'h00);
        chk("abort_flags_hold", flags(), 4'b0000);

        alu1("post_add", 4'd0, 8'h12, 8'h34, 1'b1, 8'h46, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand, result and datapath width (minimum 4).
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  high when op/a/b/fi carry a request.
REQ-005 in_ready  output  1  high when a request can be accepted this cycle.
REQ-006 op  input  4  operation select (see REQ-012).
REQ-007 a, b  input  WIDTH  operands, both unsigned, or two's-complement for the overflow flag.
REQ-008 fi  input  1  flag enable; when high, the flag outputs update with this request's result.
REQ-009 out  output  WIDTH  registered result.
REQ-010 out_valid  output  1  single-cycle pulse marking out as valid; no backpressure.
REQ-011 carry, zero, negative, overflow  output  1 each  architectural flag register.

Function
REQ-012 op encoding SHALL be: 0 ADD, 1 SUB (a-b), 2 ADC (a+b+carry), 3 SBC (a-b-carry), 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 SHL a by 1, 9 SHR a by 1 (logical), 10 MUL (low WIDTH bits of a*b), 11-15 PASS a.
REQ-013 A request SHALL be accepted on a rising edge where in_valid && in_ready; op, a, b, fi are sampled only then.
REQ-014 For all ops except MUL, latency SHALL be 1: out and out_valid=1 appear the cycle after acceptance, and in_ready SHALL stay high, allowing back-to-back acceptance every cycle.
REQ-015 MUL SHALL be iterative shift-add, one partial product per cycle, with out_valid asserted exactly WIDTH cycles after acceptance.
REQ-016 in_ready SHALL be low from the cycle after MUL acceptance until the cycle out_valid for that MUL is high, when it SHALL return to 1.
REQ-017 out SHALL hold its last value when out_valid is low.
REQ-018 Carry SHALL be set as follows: ADD/ADC = bit WIDTH of the WIDTH+1-bit sum; SUB/SBC = borrow (1 when the unsigned result is below 0); SHL = old a[WIDTH-1]; SHR = old a[0]; MUL = 1 if the high WIDTH bits of the 2*WIDTH product are nonzero; all other ops = 0.
REQ-019 Overflow SHALL be the signed two's-complement overflow for ADD/ADC/SUB/SBC and 0 for all other ops.
REQ-020 zero SHALL be set when the result equals 0, and negative SHALL equal result[WIDTH-1], for every op.
REQ-021 When fi was high at acceptance, all four flags SHALL update on the same edge that raises out_valid; when fi was low, flags SHALL be unchanged.
REQ-022 ADC/SBC SHALL use the carry produced by all previously accepted fi=1 requests, including one completing on the same edge as this acceptance; that value SHALL be forwarded, never the stale register.
REQ-023 Internal state SHALL be IDLE or MUL_BUSY only: IDLE->MUL_BUSY on MUL acceptance; MUL_BUSY->IDLE on the cycle out_valid is raised.
REQ-024 All arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 While rst is high, the block SHALL force out=0, out_valid=0, all flags=0, in_ready=0, and state=IDLE; the cycle after rst falls, in_ready SHALL be 1.
REQ-026 rst asserted during MUL_BUSY SHALL abort the multiply with no out_valid pulse for it.
REQ-027 rst SHALL take priority over any request presented in the same cycle, and that request SHALL NOT be accepted.

Verification (WIDTH=8)
REQ-028 ADD 0xFF+0x01, fi=1 -> next cycle: out=0x00, out_valid=1, carry=1, zero=1, negative=0, overflow=0.
REQ-029 ADD 0xFF+0x01 (fi=1), then ADC 0x00+0x00 (fi=1) on the next cycle -> second result 0x01, carry=0 (forwarding).
REQ-030 SUB 0x05-0x07, fi=1 -> out=0xFE, carry=1, negative=1, overflow=0; then SUB 0x80-0x01, fi=1 -> out=0x7F, overflow=1, carry=0.
REQ-031 MUL 0x0F*0x11 -> out=0xFF, carry=0, out_valid exactly 8 cycles after acceptance, in_ready low in between; MUL 0x10*0x10, fi=1 -> out=0x00, carry=1, zero=1.
REQ-032 AND 0xF0&0x0F with fi=0, after flags were set by REQ-028 -> out=0x00, flags still carry=1, zero=1.
REQ-033 rst pulsed 3 cycles after MUL acceptance -> no out_valid pulse, out=0x00, flags=0, in_ready=1 the cycle after rst falls.
